load_store_unit: RTL and testbench
==================================

# load_store_unit

Parametrised load/store unit for the RISC-V cores, replacing the fixed combinational lw/lb path in the single-cycle datapath. It decodes funct3 for every RV32I/RV64I load and store, does byte-lane alignment, strobe generation and sign/zero extension, and detects misalignment. It runs a ready/valid handshake to a multi-cycle data memory. It sits between the execute stage (address from the ALU) and the data-memory port, and signals completion back to the control unit.

## Interface
- XLEN, 32, data width: 32 or 64. Bus width = XLEN; NB = XLEN/8 byte lanes; OFS = log2(NB).
- ADDR_W, 32, byte-address width.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  execute stage presents an access.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  XLEN  store data (rs2).
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  misaligned or illegal funct3; qualified by resp_valid.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- busy  out  1  high in any state other than IDLE; the control unit stalls PC on it.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory accepts the request.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  req_addr with its low OFS bits cleared.
- mem_wstrb  out  NB  byte write strobes; all 0 for reads.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  aligned read word.

## Operation
- Legal funct3 values:
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. When XLEN=64, also 011 ld and 110 lwu.
  - Stores: 000 sb, 001 sh, 010 sw. When XLEN=64, also 011 sd.
  - Anything else is illegal.
- Misaligned conditions, using off = req_addr[OFS-1:0]:
  - halfword: off[0] != 0
  - word: off[1:0] != 0
  - doubleword: off[2:0] != 0
- Request capture: on req_valid && req_ready, the unit registers we, funct3, off, mem_addr, strobes and wdata.
- Store data:
  - mem_wdata replicates the store datum across lanes: sb gives {NB{wdata[7:0]}}, sh gives {NB/2{wdata[15:0]}}, and so on.
  - mem_wstrb = size mask << off. Example: sh at off 2 with XLEN=32 gives 4'b1100.
- Load data:
  - Extract with shifted = mem_rdata >> (8*off), then sign-extend (lb/lh/lw) or zero-extend (lbu/lhu/lwu) to XLEN.
  - The extended value is registered into resp_rdata.
- States:
  - IDLE: req_ready=1. On accept, go to RESP with resp_err=1 if the request is illegal or misaligned (no memory access). Otherwise go to REQ.
  - REQ: mem_valid=1, and address, strobes and data are held stable until mem_ready. On mem_ready, a store goes to RESP and a load goes to WAIT.
  - WAIT: mem_valid=0. On mem_rvalid, latch the extended data and go to RESP. mem_rvalid is ignored in every other state, including the REQ cycle in which mem_ready is high.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. The response has no backpressure.
- Reset values: state=IDLE, req_ready=1, and every other output 0.
- Reset mid-operation: the unit goes to IDLE immediately and mem_valid drops asynchronously. A later mem_rvalid in IDLE is ignored.

## Timing
- All outputs come from registers or decode of the state register. There is no combinational path from req_* to mem_*.
- Store with mem_ready already high: accept at edge 0, REQ during cycle 1, RESP during cycle 2, req_ready again in cycle 3. That is 3 cycles from accept to the next accept.
- Load: one cycle more than a store, plus the memory's ready-to-rvalid latency.
- Error: accept at edge 0, resp_valid in cycle 1.
- req_valid held during busy cycles has no effect.

## Structure
- Shared package/header riscv_pkg holds:
  - funct3 constants: F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - LSU state encodings: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, RESP=2'd3.
- Sub-module lsu_load_align: combinational shift and extend (mem_rdata, off, funct3 -> extended data), reused by the later pipelined core.
- The FSM and strobe generation stay in load_store_unit.

## Test plan
- XLEN=32, sb addr 0x103, wdata 0x000000A5, mem_ready held high -> mem_addr 0x100, mem_wstrb 4'b1000, mem_wdata 0xA5A5A5A5, resp_valid 2 cycles after accept, resp_err=0.
- lb addr 0x102, mem_rdata 0x12F45678 returned 3 cycles after mem_ready -> resp_rdata 0xFFFFFFF4. Repeat as lbu -> 0x000000F4.
- lh addr 0x101 -> resp_err=1 one cycle after accept, mem_valid never asserted, resp_rdata 0.
- mem_ready low for 4 cycles in REQ -> mem_valid, mem_addr and mem_wstrb stable for all 4 cycles, busy=1, req_ready=0.
- XLEN=64: lwu addr 0x4, mem_rdata 0x80000001_00000000 -> 0x0000000080000001. funct3 011 with XLEN=32 -> resp_err=1.
- Reset asserted in WAIT -> mem_valid 0 and state IDLE immediately; a subsequent mem_rvalid produces no resp_valid.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg - shared RISC-V definitions for the core datapath.
//
// Holds the load/store funct3 encodings, the load/store unit state
// encoding, and small decode helpers shared by the LSU and its
// load-alignment sub-module.
package riscv_pkg;

    // Load/store funct3 encodings. Stores use the same low two bits
    // (byte/half/word/double) with bit 2 clear.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Load/store unit state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // log2 of the access size in bytes; funct3[1:0] is b/h/w/d for
    // both loads and stores.
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        return f3[1:0];
    endfunction

    // Legal funct3 for a load (we=0) or store (we=1). The 64-bit-only
    // encodings (ld, lwu, sd) are legal only when is64 is set.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3,
                                      input logic is64);
        logic ok;
        if (we) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (is64 && (f3 == F3_D));
        end else begin
            case (f3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                F3_D, F3_WU:                    ok = is64;
                default:                        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align - combinational load data alignment and extension.
//
// Shifts the addressed bytes of an aligned memory word down to bit 0 and
// sign- or zero-extends them to XLEN according to the load funct3.
//
// Ports:
//   rdata_i   [XLEN-1:0]  aligned word returned by data memory
//   off_i     [OFS-1:0]   byte offset of the access within the word
//   funct3_i  [2:0]       load funct3 (bit 2 set = zero-extend)
//   data_o    [XLEN-1:0]  extended load result
module lsu_load_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]            rdata_i,
    input  logic [$clog2(XLEN/8)-1:0]  off_i,
    input  logic [2:0]                 funct3_i,
    output logic [XLEN-1:0]            data_o
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] left;
    int              width;
    int              pad;

    // Extension is done by pushing the datum to the top of the word and
    // shifting it back down, arithmetically for signed loads. This keeps
    // the logic identical for every size including the full-width one.
    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        width   = 8 << f3_size(funct3_i);
        if (width > XLEN) begin
            width = XLEN;
        end
        pad  = XLEN - width;
        left = shifted << pad;
        if (funct3_i[2]) begin
            data_o = left >> pad;
        end else begin
            data_o = $signed(left) >>> pad;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit - RV32I/RV64I load/store unit with a ready/valid port
// to a multi-cycle data memory.
//
// Decodes funct3, checks alignment, generates byte strobes and
// lane-replicated store data, and sign/zero-extends load data.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. req_ready is high only in IDLE; mem_valid, mem_addr,
// mem_we, mem_wstrb and mem_wdata are held stable from the first REQ
// cycle until the edge where mem_ready is seen. mem_rvalid is a one-cycle
// data strobe, honoured only in WAIT. resp_valid is a one-cycle pulse
// with no backpressure.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   req_valid/req_ready             request handshake from execute
//   req_we, req_funct3, req_addr,
//   req_wdata                       request payload
//   resp_valid, resp_err,
//   resp_rdata                      completion pulse and result
//   busy                            unit is not IDLE (PC stall)
//   mem_valid/mem_ready             memory request handshake
//   mem_we, mem_addr, mem_wstrb,
//   mem_wdata                       memory request payload
//   mem_rvalid, mem_rdata           memory read return
//   dbg_state                       current FSM state
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [XLEN-1:0]    req_wdata,
    output logic               resp_valid,
    output logic               resp_err,
    output logic [XLEN-1:0]    resp_rdata,
    output logic               busy,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [XLEN/8-1:0]  mem_wstrb,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    output lsu_state_e         dbg_state
);

    localparam int   NB   = XLEN / 8;
    localparam int   OFS  = $clog2(NB);
    localparam logic IS64 = (XLEN == 64);

    // Registered request and result.
    lsu_state_e        state_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [OFS-1:0]    off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     wstrb_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              err_q;

    // Values captured on accept.
    logic [OFS-1:0]    off_d;
    logic              ok_d;
    logic [ADDR_W-1:0] addr_d;
    logic [NB-1:0]     wstrb_d;
    logic [XLEN-1:0]   wdata_d;
    logic [NB-1:0]     size_mask;
    int                nbytes;

    logic [XLEN-1:0]   load_ext;

    always_comb begin
        nbytes = 1 << f3_size(req_funct3);
        // Only reachable for the illegal 32-bit double; keeps the mask in range.
        if (nbytes > NB) begin
            nbytes = NB;
        end
        size_mask = NB'((1 << nbytes) - 1);
        off_d     = req_addr[OFS-1:0];
        ok_d      = f3_legal(req_we, req_funct3, IS64) &&
                    ((int'(off_d) & (nbytes - 1)) == 0);
        addr_d    = {req_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
        wstrb_d   = '0;
        wdata_d   = '0;
        if (req_we && ok_d) begin
            wstrb_d = size_mask << off_d;
            // Replicate the datum into every lane so the strobes alone
            // select which bytes memory writes.
            for (int i = 0; i < NB; i++) begin
                wdata_d[8*i +: 8] = req_wdata[8*(i & (nbytes - 1)) +: 8];
            end
        end
    end

    lsu_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata_i  (mem_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (load_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= off_d;
                        addr_q  <= addr_d;
                        wstrb_q <= wstrb_d;
                        wdata_q <= wdata_d;
                        rdata_q <= '0;
                        err_q   <= ~ok_d;
                        // Bad requests skip memory and respond at once.
                        state_q <= ok_d ? REQ : RESP;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state_q <= we_q ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= load_ext;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs are registers or decodes of state_q only; nothing from
    // req_* reaches mem_* without passing through a register.
    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign mem_valid  = (state_q == REQ);
    assign mem_we     = mem_valid & we_q;
    assign mem_addr   = addr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_wdata  = wdata_q;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;
    import riscv_pkg::*;

    localparam int RQ_W = 105; // {we, wstrb[7:0], addr[31:0], wdata[63:0]}
    localparam int RS_W = 97;  // {err, rdata[63:0], response cycle[31:0]}
    localparam int TM_W = 16;  // {ready stall, rvalid latency}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0;

    logic        req_ready32, resp_valid32, resp_err32, busy32, mem_valid32, mem_we32;
    logic [31:0] resp_rdata32, mem_addr32, mem_wdata32;
    logic [3:0]  mem_wstrb32;
    logic        mem_ready32 = 1'b0, mem_rvalid32 = 1'b0;
    logic [31:0] mem_rdata32 = '0;
    lsu_state_e  dbg_state32;

    logic        req_ready64, resp_valid64, resp_err64, busy64, mem_valid64, mem_we64;
    logic [63:0] resp_rdata64, mem_wdata64;
    logic [31:0] mem_addr64;
    logic [7:0]  mem_wstrb64;
    logic        mem_ready64 = 1'b0, mem_rvalid64 = 1'b0;
    logic [63:0] mem_rdata64 = '0;
    lsu_state_e  dbg_state64;

    load_store_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready32), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .resp_valid(resp_valid32), .resp_err(resp_err32), .resp_rdata(resp_rdata32),
        .busy(busy32), .mem_valid(mem_valid32), .mem_ready(mem_ready32),
        .mem_we(mem_we32), .mem_addr(mem_addr32), .mem_wstrb(mem_wstrb32),
        .mem_wdata(mem_wdata32), .mem_rvalid(mem_rvalid32), .mem_rdata(mem_rdata32),
        .dbg_state(dbg_state32)
    );

    load_store_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready64), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid64), .resp_err(resp_err64), .resp_rdata(resp_rdata64),
        .busy(busy64), .mem_valid(mem_valid64), .mem_ready(mem_ready64),
        .mem_we(mem_we64), .mem_addr(mem_addr64), .mem_wstrb(mem_wstrb64),
        .mem_wdata(mem_wdata64), .mem_rvalid(mem_rvalid64), .mem_rdata(mem_rdata64),
        .dbg_state(dbg_state64)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_fail = 0;
    bit auto_mem = 1'b1;

    logic [RQ_W-1:0] exp_req32_q[$], exp_req64_q[$];
    logic [RS_W-1:0] exp_q32[$], exp_q64[$];
    logic [TM_W-1:0] tim32_q[$], tim64_q[$];
    logic [63:0]     word32_q[$], word64_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit legal(input int xlen, input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (xlen == 64 && f3 == 3'd3);
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5) ||
               (xlen == 64 && (f3 == 3'd3 || f3 == 3'd6));
    endfunction

    // acc is the cycle count at the negedge the request is driven; the
    // response is seen 1 (error), 2+stall (store) or 3+stall+lat (load)
    // negedges later.
    task automatic predict(input int xlen, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [63:0] wdata,
                           input logic [63:0] word, input int unsigned acc,
                           input int stall, input int lat,
                           output bit ok, output logic [RQ_W-1:0] rq, output logic [RS_W-1:0] rs);
        int nb = xlen / 8;
        int sz = 1 << f3[1:0];
        int off = int'(addr[2:0]) % nb;
        logic [7:0]  strb = '0;
        logic [63:0] wd = '0;
        logic [63:0] ld = '0;
        ok = legal(xlen, we, f3) && ((int'(addr[2:0]) % sz) == 0);
        rq = '0;
        if (!ok) begin
            rs = {1'b1, 64'h0, 32'(acc + 1)};
            return;
        end
        if (we) begin
            for (int b = 0; b < sz; b++) strb[off + b] = 1'b1;
            for (int i = 0; i < nb; i++) wd[8*i +: 8] = wdata[8*(i % sz) +: 8];
            rs = {1'b0, 64'h0, 32'(acc + 2 + stall)};
        end else begin
            for (int b = 0; b < sz; b++) ld[8*b +: 8] = word[8*(off + b) +: 8];
            if (!f3[2] && ld[8*sz - 1])
                for (int k = 8*sz; k < xlen; k++) ld[k] = 1'b1;
            rs = {1'b0, ld, 32'(acc + 3 + stall + lat)};
        end
        rq = {we, strb, addr & ~(32'(nb) - 32'd1), wd};
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [63:0] word,
                         input int stall, input int lat);
        int budget = 0;
        bit ok32, ok64;
        logic [RQ_W-1:0] rq32, rq64;
        logic [RS_W-1:0] rs32, rs64;
        @(negedge clk);
        while (!(req_ready32 && req_ready64) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) check("idle_timeout", {req_ready32, req_ready64}, 2'b11);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        predict(32, we, f3, addr, wdata, word, cyc, stall, lat, ok32, rq32, rs32);
        predict(64, we, f3, addr, wdata, word, cyc, stall, lat, ok64, rq64, rs64);
        exp_q32.push_back(rs32);
        exp_q64.push_back(rs64);
        if (ok32) begin
            exp_req32_q.push_back(rq32);
            tim32_q.push_back({8'(stall), 8'(lat)});
            if (!we) word32_q.push_back(word & 64'hFFFF_FFFF);
        end
        if (ok64) begin
            exp_req64_q.push_back(rq64);
            tim64_q.push_back({8'(stall), 8'(lat)});
            if (!we) word64_q.push_back(word);
        end
        @(negedge clk);
        // A request offered while busy must be ignored.
        if ($urandom_range(0, 1) == 1) begin
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr = $urandom;
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    // ---------------- memory responders ----------------
    initial begin : mem_resp32
        logic [RQ_W-1:0] rq;
        logic [TM_W-1:0] tm;
        logic [63:0] w;
        bit is_ld;
        forever begin
            @(negedge clk);
            if (auto_mem && mem_valid32) begin
                is_ld = !mem_we32;
                if (exp_req32_q.size() == 0) begin
                    check("mem32_unexpected_req", mem_valid32, 1'b0);
                    tm = '0;
                end else begin
                    rq = exp_req32_q.pop_front();
                    tm = tim32_q.pop_front();
                    check("mem32_addr", mem_addr32, rq[95:64]);
                    check("mem32_we", mem_we32, rq[104]);
                    check("mem32_wstrb", mem_wstrb32, rq[99:96]);
                    if (rq[104]) check("mem32_wdata", mem_wdata32, rq[31:0]);
                    repeat (int'(tm[15:8])) begin
                        @(negedge clk);
                        check("mem32_hold", {mem_valid32, busy32, req_ready32, mem_addr32, mem_wstrb32},
                              {1'b1, 1'b1, 1'b0, rq[95:64], rq[99:96]});
                    end
                end
                // rvalid during the ready cycle must not be taken as data
                mem_ready32 = 1'b1; mem_rvalid32 = 1'($urandom_range(0, 1)); mem_rdata32 = $urandom;
                @(negedge clk);
                mem_ready32 = 1'b0; mem_rvalid32 = 1'b0;
                if (is_ld) begin
                    repeat (int'(tm[7:0])) @(negedge clk);
                    w = (word32_q.size() != 0) ? word32_q.pop_front() : 64'h0;
                    mem_rvalid32 = 1'b1; mem_rdata32 = w[31:0];
                    @(negedge clk);
                    mem_rvalid32 = 1'b0;
                end
            end
        end
    end

    initial begin : mem_resp64
        logic [RQ_W-1:0] rq;
        logic [TM_W-1:0] tm;
        bit is_ld;
        forever begin
            @(negedge clk);
            if (auto_mem && mem_valid64) begin
                is_ld = !mem_we64;
                if (exp_req64_q.size() == 0) begin
                    check("mem64_unexpected_req", mem_valid64, 1'b0);
                    tm = '0;
                end else begin
                    rq = exp_req64_q.pop_front();
                    tm = tim64_q.pop_front();
                    check("mem64_addr", mem_addr64, rq[95:64]);
                    check("mem64_we", mem_we64, rq[104]);
                    check("mem64_wstrb", mem_wstrb64, rq[103:96]);
                    if (rq[104]) check("mem64_wdata", mem_wdata64, rq[63:0]);
                    repeat (int'(tm[15:8])) begin
                        @(negedge clk);
                        check("mem64_hold", {mem_valid64, busy64, req_ready64, mem_addr64, mem_wstrb64},
                              {1'b1, 1'b1, 1'b0, rq[95:64], rq[103:96]});
                    end
                end
                mem_ready64 = 1'b1; mem_rvalid64 = 1'($urandom_range(0, 1)); mem_rdata64 = {$urandom, $urandom};
                @(negedge clk);
                mem_ready64 = 1'b0; mem_rvalid64 = 1'b0;
                if (is_ld) begin
                    repeat (int'(tm[7:0])) @(negedge clk);
                    mem_rvalid64 = 1'b1;
                    mem_rdata64 = (word64_q.size() != 0) ? word64_q.pop_front() : 64'h0;
                    @(negedge clk);
                    mem_rvalid64 = 1'b0;
                end
            end
        end
    end

    // ---------------- response monitors ----------------
    initial begin : mon32
        logic [RS_W-1:0] rs;
        forever begin
            @(negedge clk);
            if (resp_valid32) begin
                if (exp_q32.size() == 0) begin
                    check("resp32_unexpected", resp_valid32, 1'b0);
                end else begin
                    rs = exp_q32.pop_front();
                    check("resp32_err", resp_err32, rs[96]);
                    check("resp32_rdata", resp_rdata32, rs[63:32]);
                    check("resp32_cycle", cyc, rs[31:0]);
                end
            end
        end
    end

    initial begin : mon64
        logic [RS_W-1:0] rs;
        forever begin
            @(negedge clk);
            if (resp_valid64) begin
                if (exp_q64.size() == 0) begin
                    check("resp64_unexpected", resp_valid64, 1'b0);
                end else begin
                    rs = exp_q64.pop_front();
                    check("resp64_err", resp_err64, rs[96]);
                    check("resp64_rdata", resp_rdata64, rs[95:32]);
                    check("resp64_cycle", cyc, rs[31:0]);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [2:0]  f3;
        logic [31:0] addr;
        int budget;

        repeat (3) @(negedge clk);
        check("reset32_ctrl", {req_ready32, busy32, mem_valid32, mem_we32, resp_valid32, resp_err32}, 6'b100000);
        check("reset32_bus", {mem_addr32, mem_wstrb32, mem_wdata32, resp_rdata32}, '0);
        check("reset32_state", dbg_state32, IDLE);
        check("reset64_ctrl", {req_ready64, busy64, mem_valid64, mem_we64, resp_valid64, resp_err64}, 6'b100000);
        check("reset64_bus", {mem_addr64, mem_wstrb64, mem_wdata64, resp_rdata64}, '0);
        check("reset64_state", dbg_state64, IDLE);
        reset = 1'b0;

        // directed cases
        issue(1'b1, F3_B,  32'h103, 64'hA5, 64'h0, 0, 0);
        issue(1'b0, F3_B,  32'h102, 64'h0, 64'h0000_0000_12F4_5678, 0, 3);
        issue(1'b0, F3_BU, 32'h102, 64'h0, 64'h0000_0000_12F4_5678, 1, 3);
        issue(1'b0, F3_H,  32'h101, 64'h0, 64'h0, 0, 0);
        issue(1'b1, F3_W,  32'h020, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 4, 0);
        issue(1'b1, F3_H,  32'h106, 64'h1234_BEEF, 64'h0, 0, 0);
        issue(1'b0, F3_H,  32'h106, 64'h0, 64'hFFEE_8001_2233_4455, 0, 0);
        issue(1'b0, F3_HU, 32'h106, 64'h0, 64'hFFEE_8001_2233_4455, 2, 1);
        issue(1'b0, F3_WU, 32'h004, 64'h0, 64'h8000_0001_0000_0000, 0, 1);
        issue(1'b0, F3_D,  32'h008, 64'h0, 64'h8000_0000_0000_0001, 0, 2);
        issue(1'b1, F3_D,  32'h018, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 0);
        issue(1'b1, F3_BU, 32'h000, 64'h55, 64'h0, 0, 0);
        issue(1'b0, 3'b111, 32'h000, 64'h0, 64'h0, 0, 0);

        // random traffic
        for (int n = 0; n < 80; n++) begin
            f3 = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
            issue(1'($urandom_range(0, 1)), f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 3), $urandom_range(0, 4));
        end

        budget = 0;
        while ((exp_q32.size() + exp_q64.size() + exp_req32_q.size() + exp_req64_q.size()) != 0 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        check("drain", exp_q32.size() + exp_q64.size() + exp_req32_q.size() + exp_req64_q.size(), 0);

        // reset while waiting for load data
        auto_mem = 1'b0;
        repeat (3) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_req_valid", {mem_valid32, mem_valid64}, 2'b11);
        mem_ready32 = 1'b1; mem_ready64 = 1'b1;
        @(negedge clk);
        mem_ready32 = 1'b0; mem_ready64 = 1'b0;
        check("rst_in_wait", {dbg_state32, dbg_state64}, {WAIT, WAIT});
        #2 reset = 1'b1;
        #1;
        check("rst_async_state", {dbg_state32, dbg_state64}, {IDLE, IDLE});
        check("rst_async_ctrl", {mem_valid32, req_ready32, busy32, mem_valid64, req_ready64, busy64}, 6'b010010);
        @(negedge clk);
        reset = 1'b0;
        mem_rvalid32 = 1'b1; mem_rdata32 = 32'hFFFF_FFFF;
        mem_rvalid64 = 1'b1; mem_rdata64 = '1;
        @(negedge clk);
        mem_rvalid32 = 1'b0; mem_rvalid64 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_resp", {resp_valid32, resp_valid64}, 2'b00);
        end

        // reset while a memory request is outstanding drops mem_valid at once
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h80;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_req2_valid", {mem_valid32, mem_valid64}, 2'b11);
        #2 reset = 1'b1;
        #1;
        check("rst_req2_drop", {mem_valid32, mem_valid64, req_ready32, req_ready64}, 4'b0011);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_req2_no_resp", {resp_valid32, resp_valid64}, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
